exttuner_ctrl: RTL and testbench
================================

Name: exttuner_ctrl

Overview:
Parametrised next-generation controller for external auto-tuners (ICOM AH-4 and level-start ATUs).
- Sequences the ATU start line from a host auto_tune request.
- Supervises the ATU status/ack line, with configurable timeouts and retry on no-response.
- Gates transmit (mox) after the sequence ends and reports a result code.
- Sits between the host control-register decode and the PTT/ATU I/O pins.

Parameters:
CLK_FREQ, 76800000, clk frequency in Hz; 1 ms prescaler reload = CLK_FREQ/1000-1
TUNE_DELAY_MS, 100, ms from request to start assertion
TUNE_WIDTH_MS, 500, start pulse width in ms (MODE_LEVEL=0 only)
LDETECT_MS, 1000, max ms to wait for ATU_Status high (ack)
HDETECT_MS, 9000, max ms for ATU_Status to return low (tuning done)
MAX_RETRY, 1, extra start attempts after an ack timeout (0..7)
TIMER_W, 16, ms timer width; must hold max(all *_MS)-1

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
auto_tune  in  1  host tune request; level, high = tune
mode_level  in  1  0 = pulse start (AH-4), 1 = level start held until ack; sampled at IDLE->DELAY only
ATU_Status  in  1  asynchronous ATU status/ack pin, active high
ATU_Start  out  1  start line to ATU, active high
mox_in  in  1  host PTT
mox_out  out  1  gated PTT = mox_in & ~mox_inhibit
busy  out  1  high in DELAY, START, WAIT_ACK, TUNING
result  out  2  0 = none/busy, 1 = tuned OK, 2 = no ack (retries exhausted), 3 = tune timeout
retry_cnt  out  3  start attempts made minus 1

Behaviour:
Reset (rst_n=0 at a clk edge):
- state=IDLE, prescaler=0, timer=0, ATU_Start=0, mox_inhibit=0, result=0, retry_cnt=0, status sync flops=0.

Prescaler:
- tick=1 when prescaler==0, then reload CLK_FREQ/1000-1; otherwise decrement.
- First tick occurs on the first clk after reset release.

Status synchroniser:
- ATU_Status passes through a 2-FF synchroniser (st_s) before use.

Abort:
- auto_tune=0 on any clk, tick or not, forces state=IDLE, ATU_Start=0, mox_inhibit=0, result=0, retry_cnt=0 on the next edge.
- Abort has priority over every transition.

Timer rule:
- Entering a timed state with duration N loads timer=N-1. On each tick, the state exits if timer==0, else the timer decrements. The state therefore lasts exactly N ticks.
- All other transitions below occur only on tick cycles.

State machine:
- IDLE: auto_tune=1 -> DELAY (TUNE_DELAY_MS); latch mode_level.
- DELAY: expiry -> START; ATU_Start<=1. Duration is TUNE_WIDTH_MS for pulse mode, LDETECT_MS for level mode.
- START, pulse mode: expiry -> WAIT_ACK (LDETECT_MS); ATU_Start<=0.
- START, level mode: st_s=1 -> TUNING (HDETECT_MS), ATU_Start<=0. Expiry without ack -> NOACK.
- WAIT_ACK (pulse mode only): st_s=1 -> TUNING (HDETECT_MS). Expiry -> NOACK.
- NOACK (internal decision, one tick):
  - retry_cnt<MAX_RETRY: retry_cnt++, -> DELAY (TUNE_DELAY_MS), ATU_Start=0.
  - otherwise: -> DONE, result=2, mox_inhibit=1.
- TUNING: st_s=0 -> DONE, result=1. Expiry with st_s still 1 -> DONE, result=3. Both set mox_inhibit=1. If st_s falls on the expiry tick itself, result=1 (success wins).
- DONE: hold all outputs until auto_tune=0.
- Unused state encodings -> IDLE.

Other rules:
- mox_out is combinational from mox_in and the mox_inhibit flop. mox passes during tuning so the ATU sees carrier.
- Level mode never retries with ATU_Start continuously high across attempts; ATU_Start is low for at least TUNE_DELAY_MS between attempts.
- Timer and retry arithmetic is unsigned; a timer at 0 never wraps, because the state exits instead.

Test Plan:
Sim params: CLK_FREQ=10000 (tick every 10 clk), TUNE_DELAY_MS=3, TUNE_WIDTH_MS=5, LDETECT_MS=10, HDETECT_MS=20, MAX_RETRY=1.
1. Pulse OK: auto_tune=1 at tick 0; ATU_Status high at tick 12, low at tick 20 -> ATU_Start high on ticks 3..7 (5 ticks); TUNING entered; DONE with result=1 at tick ~21; mox_out=0 thereafter while mox_in=1; busy=0.
2. No ack with retry: ATU_Status held 0 -> two start pulses with ATU_Start low ≥3 ticks between them; retry_cnt=1; result=2; mox_inhibit=1 after second LDETECT expiry.
3. Tune timeout: ack at tick 10, status held high -> result=3 exactly 20 ticks after TUNING entry.
4. Level mode: mode_level=1, ack at tick 6 -> ATU_Start high ticks 3..6 only, drops on the ack tick. No ack -> ATU_Start high for 10 ticks, then a retry.
5. Abort: auto_tune dropped mid-START on a non-tick cycle -> ATU_Start=0 and state IDLE on the next clk edge. Re-assertion restarts from DELAY with retry_cnt=0.
6. Reset mid-TUNING: rst_n=0 for one clk with auto_tune=1 -> all outputs reset. Sequence restarts; first ATU_Start rise 3 ticks after reset release.

Source files
------------

// File: rtl/exttuner_ctrl.sv
// exttuner_ctrl -- start/ack sequencer for external antenna tuners
// (ICOM AH-4 pulse start and level-start ATUs).
//
// A host tune request walks the ATU through a delayed start, waits for the
// ATU to acknowledge by raising its status line, then waits for status to
// fall again (tuning done). Missing acknowledges are retried up to MAX_RETRY
// times. Once the sequence ends, transmit is gated off and a result code is
// held until the host drops auto_tune.
//
// All sequencing runs on a 1 ms tick from an internal prescaler.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   auto_tune   host tune request (level); low aborts to IDLE on the next edge
//   mode_level  0 = pulse start, 1 = start held until ack (latched at request)
//   ATU_Status  asynchronous ATU status/ack pin, active high
//   ATU_Start   start line to the ATU, active high
//   mox_in      host PTT
//   mox_out     gated PTT, mox_in with the sequence-end inhibit applied
//   busy        sequence in progress
//   result      0 none/busy, 1 tuned, 2 no ack, 3 tune timeout
//   retry_cnt   start attempts made minus one
module exttuner_ctrl #(
  parameter int CLK_FREQ      = 76800000,
  parameter int TUNE_DELAY_MS = 100,
  parameter int TUNE_WIDTH_MS = 500,
  parameter int LDETECT_MS    = 1000,
  parameter int HDETECT_MS    = 9000,
  parameter int MAX_RETRY     = 1,
  parameter int TIMER_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       auto_tune,
  input  logic       mode_level,
  input  logic       ATU_Status,
  output logic       ATU_Start,
  input  logic       mox_in,
  output logic       mox_out,
  output logic       busy,
  output logic [1:0] result,
  output logic [2:0] retry_cnt
);

  localparam int PRE_DIV = CLK_FREQ / 1000;
  localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  localparam logic [PRE_W-1:0]   PRE_RELOAD = PRE_W'(PRE_DIV - 1);
  localparam logic [TIMER_W-1:0] T_DELAY    = TIMER_W'(TUNE_DELAY_MS - 1);
  localparam logic [TIMER_W-1:0] T_WIDTH    = TIMER_W'(TUNE_WIDTH_MS - 1);
  localparam logic [TIMER_W-1:0] T_LDET     = TIMER_W'(LDETECT_MS - 1);
  localparam logic [TIMER_W-1:0] T_HDET     = TIMER_W'(HDETECT_MS - 1);
  localparam logic [2:0]         RETRY_MAX  = 3'(MAX_RETRY);

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_OK      = 2'd1;
  localparam logic [1:0] RES_NOACK   = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_START    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_NOACK    = 3'd4,
    S_TUNING   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  logic [PRE_W-1:0]   prescaler;
  logic               tick;
  logic               st_meta, st_s;

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic               start_n;
  logic               mox_inhibit, inh_n;
  logic [1:0]         result_n;
  logic [2:0]         retry_n;
  logic               mode_lvl, mode_n;

  // 1 ms prescaler: starts at zero so the first tick lands on the first
  // edge after reset release.
  assign tick = (prescaler == '0);

  always_ff @(posedge clk) begin
    if (!rst_n)    prescaler <= '0;
    else if (tick) prescaler <= PRE_RELOAD;
    else           prescaler <= prescaler - PRE_W'(1);
  end

  // Status synchroniser
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_meta <= 1'b0;
      st_s    <= 1'b0;
    end else begin
      st_meta <= ATU_Status;
      st_s    <= st_meta;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      ATU_Start   <= 1'b0;
      mox_inhibit <= 1'b0;
      result      <= RES_NONE;
      retry_cnt   <= 3'd0;
      mode_lvl    <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      ATU_Start   <= start_n;
      mox_inhibit <= inh_n;
      result      <= result_n;
      retry_cnt   <= retry_n;
      mode_lvl    <= mode_n;
    end
  end

  // Next-state logic. A timed state exits on the tick where timer is zero,
  // so a load of N-1 gives exactly N ticks in the state.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    start_n  = ATU_Start;
    inh_n    = mox_inhibit;
    result_n = result;
    retry_n  = retry_cnt;
    mode_n   = mode_lvl;

    if (!auto_tune) begin
      // Dropping the request wins over everything, tick or not.
      state_n  = S_IDLE;
      timer_n  = '0;
      start_n  = 1'b0;
      inh_n    = 1'b0;
      result_n = RES_NONE;
      retry_n  = 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick) begin
            state_n = S_DELAY;
            timer_n = T_DELAY;
            mode_n  = mode_level;
          end
        end
        S_DELAY: begin
          if (tick) begin
            if (timer == '0) begin
              state_n = S_START;
              start_n = 1'b1;
              timer_n = mode_lvl ? T_LDET : T_WIDTH;
            end else begin
              timer_n = timer - TIMER_W'(1);
            end
          end
        end
        S_START: begin
          if (tick) begin
            if (mode_lvl && st_s) begin
              state_n = S_TUNING;
              timer_n = T_HDET;
              start_n = 1'b0;
            end else if (timer == '0) begin
              // Level start drops the line here too, so a retry always sees
              // ATU_Start low for a full delay period first.
              state_n = mode_lvl ? S_NOACK : S_WAIT_ACK;
              timer_n = T_LDET;
              start_n = 1'b0;
            end else begin
              timer_n = timer - TIMER_W'(1);
            end
          end
        end
        S_WAIT_ACK: begin
          if (tick) begin
            if (st_s) begin
              state_n = S_TUNING;
              timer_n = T_HDET;
            end else if (timer == '0) begin
              state_n = S_NOACK;
            end else begin
              timer_n = timer - TIMER_W'(1);
            end
          end
        end
        S_NOACK: begin
          if (tick) begin
            if (retry_cnt < RETRY_MAX) begin
              retry_n = retry_cnt + 3'd1;
              state_n = S_DELAY;
              timer_n = T_DELAY;
              start_n = 1'b0;
            end else begin
              state_n  = S_DONE;
              result_n = RES_NOACK;
              inh_n    = 1'b1;
            end
          end
        end
        S_TUNING: begin
          if (tick) begin
            // Status release is tested first so a fall on the expiry tick
            // still counts as success.
            if (!st_s) begin
              state_n  = S_DONE;
              result_n = RES_OK;
              inh_n    = 1'b1;
            end else if (timer == '0) begin
              state_n  = S_DONE;
              result_n = RES_TIMEOUT;
              inh_n    = 1'b1;
            end else begin
              timer_n = timer - TIMER_W'(1);
            end
          end
        end
        S_DONE: begin
        end
        default: begin
          state_n = S_IDLE;
          timer_n = '0;
          start_n = 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == S_DELAY) || (state == S_START) ||
                (state == S_WAIT_ACK) || (state == S_TUNING);

  // Carrier passes during tuning; only the finished sequence gates PTT.
  assign mox_out = mox_in & ~mox_inhibit;

endmodule

// File: tb/tb_exttuner_ctrl.sv
// Bench for exttuner_ctrl. Stimulus is described per 1 ms tick: the ATU
// status level visible at each tick, plus random PTT. The reference model
// derives the expected per-tick outputs from the sequence's phase lengths
// (delay, start, ack window, tuning window) rather than from a state machine.
module tb_exttuner_ctrl;

  localparam int D  = 3;
  localparam int W  = 5;
  localparam int L  = 10;
  localparam int H  = 20;
  localparam int MR = 1;
  localparam int NT = 64;
  localparam int NA = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       auto_tune = 1'b0;
  logic       mode_level = 1'b0;
  logic       ATU_Status = 1'b0;
  logic       mox_in = 1'b0;
  logic       ATU_Start, mox_out, busy;
  logic [1:0] result;
  logic [2:0] retry_cnt;

  int checks = 0;
  int fails  = 0;
  int e      = -1;

  bit         stat[NA];
  bit         mox_drv[NA];
  logic [7:0] obs_v[NA];
  bit         exp_start[NA];
  bit         exp_busy[NA];
  bit         exp_inh[NA];
  logic [1:0] exp_res[NA];
  logic [2:0] exp_retry[NA];

  always #5 clk = ~clk;

  exttuner_ctrl #(
    .CLK_FREQ(10000), .TUNE_DELAY_MS(D), .TUNE_WIDTH_MS(W),
    .LDETECT_MS(L), .HDETECT_MS(H), .MAX_RETRY(MR), .TIMER_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .auto_tune(auto_tune), .mode_level(mode_level),
    .ATU_Status(ATU_Status), .ATU_Start(ATU_Start), .mox_in(mox_in),
    .mox_out(mox_out), .busy(busy), .result(result), .retry_cnt(retry_cnt)
  );

  task automatic clk_edge();
    @(posedge clk);
    e++;
    #1;
  endtask

  // Edge 0 after reset release is a tick, then every 10th edge.
  task automatic goto_tick();
    do clk_edge(); while (e % 10 != 0);
  endtask

  function automatic logic [7:0] obs_now();
    return {ATU_Start, busy, result, retry_cnt, mox_out};
  endfunction

  function automatic logic [7:0] exp_vec(int k);
    return {exp_start[k], exp_busy[k], exp_res[k], exp_retry[k], mox_drv[k] & ~exp_inh[k]};
  endfunction

  task automatic fill(input int lo, input int hi, input int st, input int b,
                      input int r, input int rc, input int inh);
    for (int k = lo; k < hi && k < NA; k++) begin
      exp_start[k] = 1'(st);
      exp_busy[k]  = 1'(b);
      exp_res[k]   = 2'(r);
      exp_retry[k] = 3'(rc);
      exp_inh[k]   = 1'(inh);
    end
  endtask

  // Status high on ticks [a, a+h)
  task automatic set_stat(input int a, input int h);
    for (int k = 0; k < NA; k++) stat[k] = (k >= a) && (k < a + h);
  endtask

  // Request seen at tick 0. Each attempt: D ticks delay, then either a W-tick
  // pulse followed by an L-tick ack window (pulse mode) or an L-tick start
  // window that is itself the ack window (level mode). Ack is the first tick
  // inside the window with status high; tuning then ends at the first tick of
  // the next H with status low, else after H ticks with a timeout. A missed
  // ack costs one decision tick before the retry delay or the no-ack result.
  task automatic build_model(input bit lvl);
    int t, s, ws, ack, dt, res;
    fill(0, NA, 0, 0, 0, 0, 0);
    t = 0;
    for (int n = 0; n <= MR; n++) begin
      s = t + D;
      fill(t, s, 0, 1, 0, n, 0);
      if (lvl) begin
        ws = s;
        fill(s, s + L, 1, 1, 0, n, 0);
      end else begin
        ws = s + W;
        fill(s, ws, 1, 1, 0, n, 0);
        fill(ws, ws + L, 0, 1, 0, n, 0);
      end
      ack = -1;
      for (int k = ws + L; k > ws; k--) if (stat[k]) ack = k;
      if (ack >= 0) begin
        dt  = ack + H;
        res = 3;
        for (int j = ack + H; j > ack; j--) if (!stat[j]) begin dt = j; res = 1; end
        fill(ack, dt, 0, 1, 0, n, 0);
        fill(dt, NA, 0, 0, res, n, 1);
        return;
      end
      fill(ws + L, ws + L + 1, 0, 0, 0, n, 0);
      if (n == MR) fill(ws + L + 1, NA, 0, 0, 2, n, 1);
      t = ws + L + 1;
    end
  endtask

  // Returns to IDLE, raises the request just after a tick, then records the
  // outputs after each of the next nt ticks.
  task automatic run_seq(input bit lvl, input int nt);
    auto_tune  = 1'b0;
    ATU_Status = 1'b0;
    goto_tick();
    auto_tune  = 1'b1;
    mode_level = lvl;
    for (int k = 0; k < nt; k++) begin
      ATU_Status = stat[k];
      mox_drv[k] = 1'($urandom);
      mox_in     = mox_drv[k];
      goto_tick();
      if (k == 0) mode_level = 1'($urandom);
      obs_v[k] = obs_now();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; auto_tune = 1'b1; ATU_Status = 1'b1; mox_in = 1'b1;
    clk_edge(); clk_edge();
    checks++;
    if (obs_now() !== 8'b0000_0001) begin
      fails++;
      $display("FAIL reset_state: got %b required %b", obs_now(), 8'b0000_0001);
    end
    auto_tune = 1'b0; ATU_Status = 1'b0;
    rst_n = 1'b1; e = -1;
  endtask

  task automatic test_pulse_ok();
    set_stat(12, 8); build_model(0); run_seq(0, NT);
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (obs_v[k] !== exp_vec(k)) begin
        fails++;
        $display("FAIL pulse_ok tick %0d: got %b required %b", k, obs_v[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_noack_retry();
    set_stat(0, 0); build_model(0); run_seq(0, NT);
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (obs_v[k] !== exp_vec(k)) begin
        fails++;
        $display("FAIL noack_retry tick %0d: got %b required %b", k, obs_v[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_tune_timeout();
    set_stat(10, 100); build_model(0); run_seq(0, NT);
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (obs_v[k] !== exp_vec(k)) begin
        fails++;
        $display("FAIL tune_timeout tick %0d: got %b required %b", k, obs_v[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_level();
    set_stat(6, 10); build_model(1); run_seq(1, NT);
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (obs_v[k] !== exp_vec(k)) begin
        fails++;
        $display("FAIL level_ack tick %0d: got %b required %b", k, obs_v[k], exp_vec(k));
      end
    end
    set_stat(0, 0); build_model(1); run_seq(1, NT);
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (obs_v[k] !== exp_vec(k)) begin
        fails++;
        $display("FAIL level_noack tick %0d: got %b required %b", k, obs_v[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    bit lvl;
    for (int it = 0; it < 10; it++) begin
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) set_stat(0, 0);
      else set_stat($urandom_range(1, 40), $urandom_range(1, 25));
      build_model(lvl); run_seq(lvl, NT);
      for (int k = 0; k < NT; k++) begin
        checks++;
        if (obs_v[k] !== exp_vec(k)) begin
          fails++;
          $display("FAIL random%0d mode %0d tick %0d: got %b required %b",
                   it, lvl, k, obs_v[k], exp_vec(k));
        end
      end
    end
  endtask

  // Abort in the middle of the retry's start pulse, between ticks.
  task automatic test_abort();
    set_stat(0, 0); build_model(0); run_seq(0, 24);
    checks++;
    if (obs_v[23] !== exp_vec(23)) begin
      fails++;
      $display("FAIL abort_pre tick 23: got %b required %b", obs_v[23], exp_vec(23));
    end
    repeat (4) clk_edge();
    auto_tune = 1'b0;
    clk_edge();
    checks++;
    if ({ATU_Start, busy, result, retry_cnt} !== 7'd0) begin
      fails++;
      $display("FAIL abort_clear: got %b required %b", {ATU_Start, busy, result, retry_cnt}, 7'd0);
    end
    auto_tune = 1'b1; mode_level = 1'b0;
    for (int i = 0; i < 4; i++) begin
      goto_tick();
      checks++;
      if ({ATU_Start, busy, retry_cnt} !== {(i == 3), 1'b1, 3'd0}) begin
        fails++;
        $display("FAIL abort_restart tick %0d: got %b required %b",
                 i, {ATU_Start, busy, retry_cnt}, {(i == 3), 1'b1, 3'd0});
      end
    end
  endtask

  task automatic test_reset_mid_tuning();
    set_stat(12, 40); build_model(0); run_seq(0, 16);
    checks++;
    if (obs_v[15] !== exp_vec(15)) begin
      fails++;
      $display("FAIL tuning_pre tick 15: got %b required %b", obs_v[15], exp_vec(15));
    end
    ATU_Status = 1'b0;
    repeat (3) clk_edge();
    rst_n = 1'b0;
    clk_edge();
    checks++;
    if (obs_now() !== {7'd0, mox_in}) begin
      fails++;
      $display("FAIL reset_mid_tuning: got %b required %b", obs_now(), {7'd0, mox_in});
    end
    mode_level = 1'b0;
    rst_n = 1'b1; e = -1;
    for (int i = 0; i < 4; i++) begin
      goto_tick();
      checks++;
      if ({ATU_Start, busy, retry_cnt} !== {(i == 3), 1'b1, 3'd0}) begin
        fails++;
        $display("FAIL reset_restart tick %0d: got %b required %b",
                 i, {ATU_Start, busy, retry_cnt}, {(i == 3), 1'b1, 3'd0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_pulse_ok();
    test_noack_retry();
    test_tune_timeout();
    test_level();
    test_random();
    test_abort();
    test_reset_mid_tuning();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1);
  end

endmodule
